// File: rtl/mips_run_ctrl_if.sv
// mips_run_ctrl_if: control/status bundle between the run controller and its driver (bench or FPGA top).
interface mips_run_ctrl_if #(parameter int CYCLE_W = 32);
  logic start, step_mode, step, stall_F, retire_W;
  logic [31:0] instr_F;
  logic core_reset, core_hold, running, halted, timeout;
  logic [CYCLE_W-1:0] cycle_count, retired_count, stall_count;
  modport master (
    output start, step_mode, step, instr_F, stall_F, retire_W,
    input core_reset, core_hold, running, halted, timeout, cycle_count, retired_count, stall_count
  );
  modport slave (
    input start, step_mode, step, instr_F, stall_F, retire_W,
    output core_reset, core_hold, running, halted, timeout, cycle_count, retired_count, stall_count
  );
endinterface

// File: rtl/mips_run_ctrl.sv
// mips_run_ctrl: reset sequencing, halt/timeout supervision and single-step for mips_32; perf counters under MIPS_RUN_CTRL_PERF_EN.
module mips_run_ctrl #(
  parameter int          CYCLE_W      = 32,
  parameter int          RESET_CYCLES = 2,
  parameter int          MAX_CYCLES   = 20,
  parameter logic [31:0] HALT_INSTR   = 32'h0000_0000,
  parameter int          HALT_REPEAT  = 4
) (
  input logic          clock,
  input logic          reset,
  mips_run_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RESET_HOLD, RUN, STEP_WAIT, STEP_EXEC, HALTED, TIMEOUT} state_t;
  localparam logic [CYCLE_W-1:0] ONE = CYCLE_W'(1);
  state_t state_q, state_d;
  logic [CYCLE_W-1:0] cycle_q, cycle_d, hrun_q, hrun_d, rcnt_q, rcnt_d;
  logic adv, restart, is_halt, is_timeout;
  always_comb begin
    adv        = state_q == RUN || state_q == STEP_EXEC;
    restart    = bus.start && (state_q == IDLE || state_q == HALTED || state_q == TIMEOUT);
    cycle_d    = restart ? '0 : (adv && !(&cycle_q)) ? cycle_q + ONE : cycle_q;
    hrun_d     = restart ? '0 : (!adv || bus.stall_F) ? hrun_q : (bus.instr_F == HALT_INSTR) ? hrun_q + ONE : '0;
    rcnt_d     = restart ? '0 : (state_q == RESET_HOLD) ? rcnt_q + ONE : rcnt_q;
    is_halt    = adv && hrun_d == CYCLE_W'(HALT_REPEAT);
    is_timeout = adv && MAX_CYCLES != 0 && cycle_d == CYCLE_W'(MAX_CYCLES);
    state_d    = state_q;
    case (state_q)
      IDLE, HALTED, TIMEOUT: state_d = bus.start ? RESET_HOLD : state_q;
      RESET_HOLD:            state_d = (rcnt_q == CYCLE_W'(RESET_CYCLES - 1)) ? (bus.step_mode ? STEP_WAIT : RUN) : RESET_HOLD;
      RUN:                   state_d = is_halt ? HALTED : is_timeout ? TIMEOUT : bus.step_mode ? STEP_WAIT : RUN;
      STEP_WAIT:             state_d = !bus.step_mode ? RUN : bus.step ? STEP_EXEC : STEP_WAIT;
      STEP_EXEC:             state_d = is_halt ? HALTED : is_timeout ? TIMEOUT : STEP_WAIT;
      default:               state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cycle_q <= '0;
      hrun_q  <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
      hrun_q  <= hrun_d;
      rcnt_q  <= rcnt_d;
    end
  end
  // every status output is a pure decode of registered state
  assign bus.core_reset  = state_q == IDLE || state_q == RESET_HOLD;
  assign bus.core_hold   = !(state_q == RUN || state_q == STEP_EXEC);
  assign bus.running     = state_q == RUN || state_q == STEP_WAIT || state_q == STEP_EXEC;
  assign bus.halted      = state_q == HALTED;
  assign bus.timeout     = state_q == TIMEOUT;
  assign bus.cycle_count = cycle_q;
`ifdef MIPS_RUN_CTRL_PERF_EN
  logic [CYCLE_W-1:0] retired_q, retired_d, stall_q, stall_d;
  always_comb begin
    retired_d = restart ? '0 : (adv && bus.retire_W && !(&retired_q)) ? retired_q + ONE : retired_q;
    stall_d   = restart ? '0 : (adv && bus.stall_F && !(&stall_q)) ? stall_q + ONE : stall_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      retired_q <= retired_d;
      stall_q   <= stall_d;
    end
  end
  assign bus.retired_count = retired_q;
  assign bus.stall_count   = stall_q;
`else
  assign bus.retired_count = '0;
  assign bus.stall_count   = '0;
`endif
endmodule

// File: tb/tb_mips_run_ctrl.sv
// tb_mips_run_ctrl: directed and random runs checked each cycle against a flag-based run model.
module tb_mips_run_ctrl;
  localparam int RC = 2, MAXC = 20, HREP = 4;
  localparam logic [31:0] HALT = 32'h0, NZ = 32'h2008_0005;
`ifdef MIPS_RUN_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b1;
  always #5 clock = ~clock;
  mips_run_ctrl_if #(.CYCLE_W(32)) bus ();
  mips_run_ctrl #(.CYCLE_W(32), .RESET_CYCLES(RC), .MAX_CYCLES(MAXC), .HALT_INSTR(HALT), .HALT_REPEAT(HREP))
    dut (.clock(clock), .reset(reset), .bus(bus));
  int n_cmp = 0, n_bad = 0, pat = 0;
  bit m_live, m_halted, m_timeout, m_paused, m_grant;
  int m_hold, m_run;
  longint m_cyc, m_ret, m_stl;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic longint inc_sat(input longint v);
    return (v >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v + 1;
  endfunction
  task automatic clear_counts();
    m_run = 0; m_cyc = 0; m_ret = 0; m_stl = 0;
  endtask
  task automatic model_step(input bit rst, st, sm, sp, stl, ret, input logic [31:0] ins);
    bit adv;
    adv = m_live && m_hold == 0 && !m_paused;
    if (rst) begin
      m_live = 0; m_halted = 0; m_timeout = 0; m_paused = 0; m_grant = 0; m_hold = 0;
      clear_counts();
    end else if (!m_live) begin
      if (st) begin
        m_live = 1; m_hold = RC; m_halted = 0; m_timeout = 0; m_paused = 0; m_grant = 0;
        clear_counts();
      end
    end else if (m_hold > 0) begin
      m_hold--;
      if (m_hold == 0) m_paused = sm;
    end else if (adv) begin
      m_cyc = inc_sat(m_cyc);
      if (ret) m_ret = inc_sat(m_ret);
      if (stl) m_stl = inc_sat(m_stl);
      else m_run = (ins == HALT) ? m_run + 1 : 0;
      if (m_run == HREP) begin m_halted = 1; m_live = 0; end
      else if (MAXC != 0 && m_cyc == MAXC) begin m_timeout = 1; m_live = 0; end
      else m_paused = m_grant || sm;
      m_grant = 0;
    end else if (!sm) m_paused = 0;
    else if (sp) begin m_paused = 0; m_grant = 1; end
  endtask
  task automatic tick();
    bit rst, st, sm, sp, stl, ret;
    logic [31:0] ins;
    rst = reset; st = bus.start; sm = bus.step_mode; sp = bus.step;
    stl = bus.stall_F; ret = bus.retire_W; ins = bus.instr_F;
    @(posedge clock);
    #1;
    model_step(rst, st, sm, sp, stl, ret, ins);
    check("core_reset", bus.core_reset, (!m_live && !m_halted && !m_timeout) || (m_live && m_hold > 0));
    check("core_hold", bus.core_hold, !(m_live && m_hold == 0 && !m_paused));
    check("running", bus.running, m_live && m_hold == 0);
    check("halted", bus.halted, m_halted);
    check("timeout", bus.timeout, m_timeout);
    check("cycle_count", bus.cycle_count, 32'(m_cyc));
    check("retired_count", bus.retired_count, PERF ? 32'(m_ret) : 32'h0);
    check("stall_count", bus.stall_count, PERF ? 32'(m_stl) : 32'h0);
  endtask
  task automatic stim();
    bus.stall_F = 1'b0;
    bus.retire_W = 1'b0;
    case (pat)
      1: bus.instr_F = (m_cyc < 5) ? NZ : HALT;
      2: begin bus.instr_F = HALT; bus.stall_F = (m_cyc == 2); end
      3: bus.instr_F = (m_cyc % 3 == 2) ? NZ : HALT;
      4: begin bus.instr_F = NZ; bus.retire_W = (m_cyc < 7); bus.stall_F = (m_cyc == 10 || m_cyc == 11); end
      default: bus.instr_F = NZ;
    endcase
  endtask
  task automatic run_to_end(input int budget);
    for (int i = 0; i < budget && !(bus.halted || bus.timeout); i++) begin
      stim();
      tick();
    end
  endtask
  task automatic do_reset();
    reset = 1'b1; bus.start = 1'b0; bus.step = 1'b0;
    tick();
    reset = 1'b0;
  endtask
  task automatic start_run(input int p, input bit sm);
    pat = p; bus.step_mode = sm; bus.start = 1'b1;
    stim();
    tick();
    bus.start = 1'b0;
  endtask
  initial begin
    int n;
    bus.start = 0; bus.step_mode = 0; bus.step = 0; bus.instr_F = NZ; bus.stall_F = 0; bus.retire_W = 0;
    m_live = 0; m_halted = 0; m_timeout = 0; m_paused = 0; m_grant = 0; m_hold = 0;
    clear_counts();
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("rst_core_reset", bus.core_reset, 1'b1);
    check("rst_core_hold", bus.core_hold, 1'b1);
    check("rst_running", bus.running, 1'b0);
    check("rst_cycles", bus.cycle_count, 32'h0);
    start_run(0, 1'b0);
    n = 0;
    for (int i = 0; i < 40 && !bus.timeout; i++) begin
      n += int'(bus.core_reset);
      stim();
      tick();
    end
    check("reset_hold_len", 32'(n), 32'(RC));
    check("to_timeout", bus.timeout, 1'b1);
    check("to_cycles", bus.cycle_count, 32'(MAXC));
    check("to_halted", bus.halted, 1'b0);
    tick();
    check("to_hold", bus.core_hold, 1'b1);
    start_run(1, 1'b0);
    run_to_end(40);
    check("halt_flag", bus.halted, 1'b1);
    check("halt_cycles", bus.cycle_count, 32'd9);
    check("halt_no_to", bus.timeout, 1'b0);
    start_run(2, 1'b0);
    run_to_end(40);
    check("stall_halt", bus.halted, 1'b1);
    check("stall_cycles", bus.cycle_count, 32'd5);
    start_run(3, 1'b0);
    run_to_end(40);
    check("broken_run_halt", bus.halted, 1'b0);
    check("broken_run_to", bus.timeout, 1'b1);
    start_run(0, 1'b1);
    n = 0;
    repeat (RC) tick();
    for (int k = 0; k < 3; k++) begin
      bus.step = 1'b1;
      tick();
      n += int'(!bus.core_hold);
      bus.step = 1'b0;
      repeat (4) begin tick(); n += int'(!bus.core_hold); end
    end
    check("step_adv_cycles", 32'(n), 32'd3);
    check("step_cycles", bus.cycle_count, 32'd3);
    bus.step_mode = 1'b0;
    for (int i = 0; i < 20 && bus.cycle_count != 6; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_core_reset", bus.core_reset, 1'b1);
    check("mid_rst_running", bus.running, 1'b0);
    check("mid_rst_cycles", bus.cycle_count, 32'h0);
    start_run(4, 1'b0);
    run_to_end(40);
    check("perf_retired", bus.retired_count, PERF ? 32'd7 : 32'd0);
    check("perf_stalls", bus.stall_count, PERF ? 32'd2 : 32'd0);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      bus.start = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 29) == 0) bus.step_mode = ~bus.step_mode;
      bus.step = ($urandom_range(0, 2) == 0);
      bus.instr_F = ($urandom_range(0, 9) < 4) ? HALT : $urandom;
      bus.stall_F = ($urandom_range(0, 4) == 0);
      bus.retire_W = $urandom_range(0, 1) == 1;
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mips_run_ctrl.md
# mips_run_ctrl

Synthesizable run-control and supervision block for the 5-stage `mips_32` core, placed between the top-level clock/reset and the core. It sequences core reset, counts executed cycles, and detects program completion by watching for a halt instruction at fetch. It also enforces a cycle-budget timeout and supports single-step execution by freezing the whole pipeline. With it, benches and FPGA top levels end runs on a defined condition instead of a fixed clock-toggle count.

## Interface
Parameters:
- `CYCLE_W`, 32: width of all counters.
- `RESET_CYCLES`, 2: cycles `core_reset` stays high after `start`; must be ≥1.
- `MAX_CYCLES`, 20: advancing-cycle budget before timeout; 0 disables the timeout.
- `HALT_INSTR`, 32'h0000_0000: instruction word treated as a halt marker.
- `HALT_REPEAT`, 4: number of consecutive unstalled fetches of `HALT_INSTR` that declare the program halted. This lets the pipeline drain.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: level-sampled; begins a run from IDLE, HALTED or TIMEOUT.
- `step_mode` in 1: 1 selects single-step execution.
- `step` in 1: level-sampled in STEP_WAIT; each sample advances the core by one cycle.
- `instr_F` in 32: fetch-stage instruction from the core.
- `stall_F` in 1: fetch stall from the core's hazard unit.
- `retire_W` in 1: a valid instruction is in writeback this cycle.
- `core_reset` out 1: reset to the core, active-high.
- `core_hold` out 1: freezes every pipeline stage. It is ORed into the core's stall_F..stall_W.
- `running` out 1: high in RUN, STEP_WAIT and STEP_EXEC.
- `halted` out 1: sticky, set on halt detection.
- `timeout` out 1: sticky, set when the budget is exhausted.
- `cycle_count` out `CYCLE_W`: number of advancing cycles completed.
- `retired_count` out `CYCLE_W`: retired-instruction count (performance counter).
- `stall_count` out `CYCLE_W`: stalled-fetch count (performance counter).

## Operation
- States: IDLE, RESET_HOLD, RUN, STEP_WAIT, STEP_EXEC, HALTED, TIMEOUT.
- Reset values:
  - State is IDLE.
  - `core_reset`=1, `core_hold`=1.
  - `running`, `halted` and `timeout` are 0.
  - All counters and the internal reset and halt-run counters are 0.
- IDLE: the core is held in reset. `start`=1 moves to RESET_HOLD and clears `cycle_count`, the perf counters and the halt-run counter.
- RESET_HOLD: `core_reset`=1 for exactly RESET_CYCLES cycles. It then moves to RUN if `step_mode`=0, or to STEP_WAIT if `step_mode`=1.
- RUN:
  - `core_reset`=0 and `core_hold`=0. Every cycle is an advancing cycle.
  - `step_mode`=1 moves to STEP_WAIT at the next edge.
  - `start` is ignored.
- STEP_WAIT: `core_hold`=1 and no counting. `step`=1 moves to STEP_EXEC. `step_mode`=0 moves to RUN.
- STEP_EXEC: `core_hold`=0 for exactly one advancing cycle, then returns to STEP_WAIT. If `step` is held high, the core advances every second cycle.
- Advancing cycle:
  - `cycle_count` increments, saturating at all-ones.
  - If `stall_F`=0 and `instr_F`==HALT_INSTR, the halt-run counter increments.
  - If `stall_F`=0 and `instr_F`!=HALT_INSTR, the halt-run counter clears.
  - If `stall_F`=1, the halt-run counter holds.
- Halt: when the halt-run counter reaches HALT_REPEAT, the next state is HALTED.
- Timeout: when `cycle_count` reaches MAX_CYCLES (and MAX_CYCLES≠0), the next state is TIMEOUT.
- If halt and timeout qualify in the same cycle, HALTED wins and `timeout` stays 0.
- HALTED and TIMEOUT:
  - `core_hold`=1 and `core_reset`=0, so the architectural state remains inspectable.
  - Flags are sticky. `start` restarts through RESET_HOLD and clears the flags.
- `reset` has priority over everything. Asserting it mid-run returns the block to IDLE at the next edge.

## Timing
- All outputs are registered and decoded from the state register. There is no combinational input-to-output path.
- After `start` is sampled at edge k: `core_reset` is high for cycles k+1..k+RESET_CYCLES, and the first advancing cycle is k+RESET_CYCLES+1.
- Halt response: `halted` and `core_hold` rise in the cycle after the HALT_REPEAT-th qualifying fetch. That fetch cycle itself advanced and was counted.
- Timeout response: `timeout` rises in the cycle after the MAX_CYCLES-th advancing cycle, and `cycle_count` then equals MAX_CYCLES.

## Configuration
- Macro: `MIPS_RUN_CTRL_PERF_EN`.
- When defined:
  - `retired_count` increments on advancing cycles with `retire_W`=1.
  - `stall_count` increments on advancing cycles with `stall_F`=1.
  - Both saturate, and both clear on `reset` and on `start`.
- When undefined: both outputs are tied to 0, no counter flops are built, and `retire_W` is unused.

## Test plan
- Default parameters, `start` pulse, `instr_F`=32'h2008_0005 forever, `stall_F`=0 -> `core_reset` high for 2 cycles; `timeout`=1 with `cycle_count`=20 and `halted`=0; `core_hold`=1 afterwards.
- Nonzero instructions for 5 advancing cycles, then `instr_F`=0 -> `halted`=1 after the 4th zero, `cycle_count`=9, `timeout`=0.
- Zeros at fetch with one `stall_F`=1 cycle inserted after the 2nd zero -> halt after the 4th unstalled zero and `cycle_count`=5. A nonzero unstalled fetch after the 2nd zero clears the run and no halt occurs.
- `step_mode`=1 with three 1-cycle `step` pulses spaced 5 cycles apart -> `core_hold` low in exactly 3 cycles and `cycle_count`=3.
- `reset` asserted at RUN cycle 6 -> next cycle IDLE, `core_reset`=1, `running`=0, all counters 0.
- `MIPS_RUN_CTRL_PERF_EN` defined, `retire_W` high in 7 advancing cycles, `stall_F` high in 2 -> `retired_count`=7, `stall_count`=2. Same run without the macro -> both read 0.
